io_out_demux: RTL and testbench
===============================

# io_out_demux

Output-side counterpart of the CPU's input-port selector. It captures each OUT-instruction write (`PORT_ID`, `OUT_PORT`, `IO_STRB`) into one of four registered output channels. Each channel has its own valid/acknowledge handshake toward its peripheral, a sticky overrun flag, and a shared saturating counter of writes to unmapped port IDs. It sits between the CPU's I/O bus and the board peripherals (LEDs, seven-segment display, and similar).

## Interface
- `n`, 8: data width of `OUT_PORT` and of each channel register.
- `P0_ID`, 8'h40: port ID decoded to channel 0.
- `P1_ID`, 8'h41: port ID decoded to channel 1.
- `P2_ID`, 8'h42: port ID decoded to channel 2.
- `P3_ID`, 8'h43: port ID decoded to channel 3.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous reset, active-low.
- `IO_STRB` in 1: write strobe, one cycle per OUT instruction.
- `PORT_ID` in 8: target port ID, valid while `IO_STRB`=1.
- `OUT_PORT` in n: write data, valid while `IO_STRB`=1.
- `ACK` in 4: per-channel consume pulse from the peripheral.
- `OVR_CLR` in 4: per-channel clear of the sticky overrun flag.
- `D0`, `D1`, `D2`, `D3` out n each: registered channel data.
- `VALID` out 4: per-channel unconsumed-data flag.
- `OVR` out 4: per-channel sticky overrun flag.
- `MISS_CNT` out 4: count of strobes to unmapped IDs, saturating at 15.

## Operation
- Decode:
  - `hit[i]` = `IO_STRB` & (`PORT_ID` == `Pi_ID`).
  - If parameters collide, the lowest index wins, so at most one `hit` is set per cycle.
- Write on `hit[i]`:
  - `Di` ← `OUT_PORT`.
  - `VALID[i]` ← 1.
- Per-channel handshake, one 2-state FSM per channel (EMPTY = `VALID`=0, FULL = `VALID`=1):
  - EMPTY, hit → FULL.
  - EMPTY, `ACK` without hit → EMPTY; `ACK` is ignored, no error.
  - FULL, `ACK` without hit → EMPTY; `Di` is retained, not cleared.
  - FULL, hit without `ACK` → FULL; `Di` is overwritten with the new data and `OVR[i]` ← 1.
  - FULL, hit and `ACK` in the same cycle → FULL with the new data and no overrun. The old data is considered consumed.
- Overrun:
  - `OVR[i]` is sticky until `OVR_CLR[i]`=1.
  - If `OVR_CLR[i]` and a new overrun occur in the same cycle, the set wins (`OVR[i]`=1).
- Miss counter:
  - Increments when `IO_STRB`=1 and no `hit`.
  - Holds at 4'hF.
  - Cleared only by reset.
- `IO_STRB`=0: `PORT_ID` and `OUT_PORT` are don't-care; no state changes except from `ACK` and `OVR_CLR`.
- Channels are fully independent. `ACK` and `OVR_CLR` on channel j never affect channel i.

## Timing
- Reset (`RST_N`=0, asynchronous, takes effect immediately without a clock edge):
  - `D0`–`D3` = 0.
  - `VALID` = 4'b0000.
  - `OVR` = 4'b0000.
  - `MISS_CNT` = 0.
- Reset release is synchronous in effect: the first update occurs on the first rising `CLK` with `RST_N`=1.
- Reset asserted mid-handshake drops `VALID` and the data immediately. A pending `ACK` in that cycle is lost.
- Write latency:
  - Strobe sampled at edge k → `Di`/`VALID[i]` updated after edge k, visible in cycle k+1.
  - No combinational path from inputs to outputs; all outputs come straight from registers.
- `ACK`:
  - Sampled at edge k → `VALID[i]` falls after edge k.
  - A peripheral holding `ACK` high for several cycles is harmless. Each cycle behaves as specified above, so a held `ACK` also clears any data written while it is held.
- Back-to-back strobes on consecutive cycles are supported. Each is processed independently.
- Throughput: one write per clock across all channels.

## Test plan
- Reset and basic write:
  - Stimulus: `RST_N`=0, then release; strobe ID 8'h41 with data 8'hA5.
  - Required: all outputs 0 during reset; one cycle after the strobe, `D1`=8'hA5 and `VALID`=4'b0010; other channels unchanged.
- Handshake:
  - Stimulus: write ch0 8'h3C, then pulse `ACK[0]` two cycles later.
  - Required: `VALID[0]` goes 1→0 one edge after the `ACK`; `D0` stays 8'h3C; `OVR[0]`=0.
- Overrun:
  - Stimulus: write ch2 8'h11, then write ch2 8'h22 with no `ACK`.
  - Required: `D2`=8'h22, `VALID[2]`=1, `OVR[2]`=1.
  - Follow-up: `OVR_CLR[2]` alone → `OVR[2]`=0. Then `OVR_CLR[2]` in the same cycle as another overrun → `OVR[2]`=1.
- Simultaneous `ACK` and write:
  - Stimulus: with ch3 FULL, strobe ch3 8'h77 in the same cycle as `ACK[3]`.
  - Required: `D3`=8'h77, `VALID[3]`=1, `OVR[3]`=0.
- Miss counter saturation:
  - Stimulus: 17 strobes to ID 8'h00.
  - Required: `MISS_CNT` steps 1..15 and then holds at 15; no `VALID` bits set. `IO_STRB`=0 with ID 8'h00 does not count.
- Asynchronous reset mid-operation:
  - Stimulus: channels 0–3 all FULL, ch1 `OVR` set; drop `RST_N` between clock edges.
  - Required: all outputs return to 0 before the next `CLK` edge.

Source files
------------

// File: rtl/io_out_demux_if.sv
// CPU OUT-port bus toward the output demux, plus the per-channel peripheral
// handshake and status lines.
interface io_out_demux_if #(
  parameter int n = 8
);
  logic         IO_STRB;
  logic [7:0]   PORT_ID;
  logic [n-1:0] OUT_PORT;
  logic [3:0]   ACK;
  logic [3:0]   OVR_CLR;
  logic [n-1:0] D0;
  logic [n-1:0] D1;
  logic [n-1:0] D2;
  logic [n-1:0] D3;
  logic [3:0]   VALID;
  logic [3:0]   OVR;
  logic [3:0]   MISS_CNT;

  modport master (
    output IO_STRB, PORT_ID, OUT_PORT, ACK, OVR_CLR,
    input  D0, D1, D2, D3, VALID, OVR, MISS_CNT
  );

  modport slave (
    input  IO_STRB, PORT_ID, OUT_PORT, ACK, OVR_CLR,
    output D0, D1, D2, D3, VALID, OVR, MISS_CNT
  );
endinterface

// File: rtl/io_out_demux.sv
// Captures OUT-instruction writes into four registered output channels, each
// with a valid/ack handshake and sticky overrun flag, plus an unmapped-ID counter.
module io_out_demux #(
  parameter int         n     = 8,
  parameter logic [7:0] P0_ID = 8'h40,
  parameter logic [7:0] P1_ID = 8'h41,
  parameter logic [7:0] P2_ID = 8'h42,
  parameter logic [7:0] P3_ID = 8'h43
) (
  input logic         CLK,
  input logic         RST_N,
  io_out_demux_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t  state_q [4];
  chan_state_t  state_d [4];
  logic [n-1:0] data_q  [4];
  logic [n-1:0] data_d  [4];
  logic [7:0]   ids     [4];
  logic [3:0]   hit;
  logic         taken;
  logic [3:0]   ovr_q;
  logic [3:0]   ovr_d;
  logic [3:0]   ovr_set;
  logic [3:0]   valid;
  logic [3:0]   miss_q;

  assign ids[0] = P0_ID;
  assign ids[1] = P1_ID;
  assign ids[2] = P2_ID;
  assign ids[3] = P3_ID;

  // Lowest index wins if parameter IDs collide, so at most one hit per cycle.
  always_comb begin
    hit   = '0;
    taken = 1'b0;
    if (bus.IO_STRB) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!taken && bus.PORT_ID == ids[i]) begin
          hit[i] = 1'b1;
          taken  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ovr_set = '0;
    ovr_d   = ovr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (hit[i]) begin
            state_d[i] = FULL;
            data_d[i]  = bus.OUT_PORT;
          end
        end
        FULL: begin
          // A write with a same-cycle ACK counts the old data as consumed.
          if (hit[i]) begin
            data_d[i]  = bus.OUT_PORT;
            ovr_set[i] = !bus.ACK[i];
          end else if (bus.ACK[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
      if (ovr_set[i])
        ovr_d[i] = 1'b1;
      else if (bus.OVR_CLR[i])
        ovr_d[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
      ovr_q  <= '0;
      miss_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      ovr_q <= ovr_d;
      if (bus.IO_STRB && !taken && miss_q != 4'hF)
        miss_q <= miss_q + 4'd1;
    end
  end

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < 4; i++)
      valid[i] = (state_q[i] == FULL);
  end

  assign bus.D0       = data_q[0];
  assign bus.D1       = data_q[1];
  assign bus.D2       = data_q[2];
  assign bus.D3       = data_q[3];
  assign bus.VALID    = valid;
  assign bus.OVR      = ovr_q;
  assign bus.MISS_CNT = miss_q;

endmodule

// File: tb/tb_io_out_demux.sv
// Scoreboard bench for io_out_demux: each step pushes its expected output
// snapshot {D0,D1,D2,D3,VALID,OVR,MISS_CNT} and pops it once the edge has passed.
module tb_io_out_demux;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  io_out_demux_if #(.n(8)) bus ();

  io_out_demux #(
    .n(8), .P0_ID(8'h40), .P1_ID(8'h41), .P2_ID(8'h42), .P3_ID(8'h43)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        s;
    logic [7:0]  id;
    logic [7:0]  dat;
    logic [3:0]  ack;
    logic [3:0]  clr;
    logic [43:0] exp;
  } step_t;

  logic [43:0] sb [$];
  logic [43:0] exp_v;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic logic [43:0] mk(input logic [7:0] d0, input logic [7:0] d1,
                                     input logic [7:0] d2, input logic [7:0] d3,
                                     input logic [3:0] v, input logic [3:0] o,
                                     input logic [3:0] m);
    return {d0, d1, d2, d3, v, o, m};
  endfunction

  function automatic step_t st(input logic s, input logic [7:0] id, input logic [7:0] dat,
                               input logic [3:0] ack, input logic [3:0] clr,
                               input logic [43:0] e);
    step_t t;
    t.s = s; t.id = id; t.dat = dat; t.ack = ack; t.clr = clr; t.exp = e;
    return t;
  endfunction

  function automatic logic [43:0] obs();
    return {bus.D0, bus.D1, bus.D2, bus.D3, bus.VALID, bus.OVR, bus.MISS_CNT};
  endfunction

  task automatic idle_bus();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.ACK      = 4'h0;
    bus.OVR_CLR  = 4'h0;
  endtask

  // Drive one cycle of stimulus, record its expectation, return 1 ns after the edge.
  task automatic apply(input step_t t);
    bus.IO_STRB  = t.s;
    bus.PORT_ID  = t.id;
    bus.OUT_PORT = t.dat;
    bus.ACK      = t.ack;
    bus.OVR_CLR  = t.clr;
    sb.push_back(t.exp);
    @(posedge CLK);
    #1;
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    RST_N = 1'b0;
    #2;
    sb.push_back('0);
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want %h", obs(), exp_v);
    end
    // Strobe while reset is held: must be ignored.
    bus.IO_STRB = 1'b1; bus.PORT_ID = 8'h40; bus.OUT_PORT = 8'hEE;
    sb.push_back('0);
    @(posedge CLK); #1;
    idle_bus();
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs(), exp_v);
    end
    RST_N = 1'b1;
    apply(st(0, 8'h00, 8'h00, 4'h0, 4'h0, '0));
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_basic_write();
    apply(st(1, 8'h41, 8'hA5, 4'h0, 4'h0, mk(8'h00, 8'hA5, 8'h00, 8'h00, 4'b0010, 4'b0000, 4'd0)));
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL basic_write: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_handshake();
    step_t s [$];
    s.push_back(st(1, 8'h40, 8'h3C, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h00, 8'h00, 4'b0011, 4'b0000, 4'd0)));
    s.push_back(st(0, 8'h40, 8'h99, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h00, 8'h00, 4'b0011, 4'b0000, 4'd0)));
    s.push_back(st(0, 8'h00, 8'h00, 4'h1, 4'h0, mk(8'h3C, 8'hA5, 8'h00, 8'h00, 4'b0010, 4'b0000, 4'd0)));
    s.push_back(st(0, 8'h00, 8'h00, 4'h1, 4'h0, mk(8'h3C, 8'hA5, 8'h00, 8'h00, 4'b0010, 4'b0000, 4'd0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL handshake[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_overrun();
    step_t s [$];
    s.push_back(st(1, 8'h42, 8'h11, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h11, 8'h00, 4'b0110, 4'b0000, 4'd0)));
    s.push_back(st(1, 8'h42, 8'h22, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h22, 8'h00, 4'b0110, 4'b0100, 4'd0)));
    s.push_back(st(0, 8'h00, 8'h00, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h22, 8'h00, 4'b0110, 4'b0100, 4'd0)));
    s.push_back(st(0, 8'h00, 8'h00, 4'h0, 4'h4, mk(8'h3C, 8'hA5, 8'h22, 8'h00, 4'b0110, 4'b0000, 4'd0)));
    s.push_back(st(1, 8'h42, 8'h33, 4'h0, 4'h4, mk(8'h3C, 8'hA5, 8'h33, 8'h00, 4'b0110, 4'b0100, 4'd0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL overrun[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_ack_and_write();
    step_t s [$];
    s.push_back(st(1, 8'h43, 8'h55, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h33, 8'h55, 4'b1110, 4'b0100, 4'd0)));
    s.push_back(st(1, 8'h43, 8'h77, 4'h8, 4'h0, mk(8'h3C, 8'hA5, 8'h33, 8'h77, 4'b1110, 4'b0100, 4'd0)));
    s.push_back(st(0, 8'h43, 8'h00, 4'h8, 4'h0, mk(8'h3C, 8'hA5, 8'h33, 8'h77, 4'b0110, 4'b0100, 4'd0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL ack_and_write[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_miss_saturation();
    step_t s [$];
    for (int k = 1; k <= 17; k++)
      s.push_back(st(1, 8'h00, 8'h5A, 4'h0, 4'h0,
                     mk(8'h3C, 8'hA5, 8'h33, 8'h77, 4'b0110, 4'b0100, (k > 15) ? 4'd15 : 4'(k))));
    s.push_back(st(0, 8'h00, 8'h5A, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h33, 8'h77, 4'b0110, 4'b0100, 4'd15)));
    s.push_back(st(0, 8'h40, 8'hFF, 4'h0, 4'h0, mk(8'h3C, 8'hA5, 8'h33, 8'h77, 4'b0110, 4'b0100, 4'd15)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL miss_saturation[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
  endtask

  // Back-to-back writes fill every channel (ch1 overruns), then reset drops mid-cycle.
  task automatic test_back_to_back_async_reset();
    step_t s [$];
    s.push_back(st(1, 8'h40, 8'h01, 4'h0, 4'h0, mk(8'h01, 8'hA5, 8'h33, 8'h77, 4'b0111, 4'b0100, 4'd15)));
    s.push_back(st(1, 8'h41, 8'h02, 4'h0, 4'h0, mk(8'h01, 8'h02, 8'h33, 8'h77, 4'b0111, 4'b0110, 4'd15)));
    s.push_back(st(1, 8'h41, 8'h03, 4'h0, 4'h0, mk(8'h01, 8'h03, 8'h33, 8'h77, 4'b0111, 4'b0110, 4'd15)));
    s.push_back(st(1, 8'h43, 8'h04, 4'h0, 4'h0, mk(8'h01, 8'h03, 8'h33, 8'h04, 4'b1111, 4'b0110, 4'd15)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
    // Reset with an ACK pending: everything must clear before the next edge.
    #2;
    bus.ACK = 4'hF;
    RST_N   = 1'b0;
    sb.push_back('0);
    #1;
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs(), exp_v);
    end
    @(posedge CLK); #1;
    idle_bus();
    RST_N = 1'b1;
    apply(st(0, 8'h00, 8'h00, 4'h0, 4'h0, '0));
    exp_v = sb.pop_front();
    n_chk++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset_release: got %h want %h", obs(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_handshake();
    test_overrun();
    test_ack_and_write();
    test_miss_saturation();
    test_back_to_back_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
